div_sweep_ctrl: RTL and testbench
=================================

# div_sweep_ctrl

Sequencer for a runtime-programmable clock divider that sweeps the division ratio from a start value to a stop value in fixed increments. It holds each ratio for a programmed number of output periods and changes ratio only at period boundaries, so `clk_div` never glitches. It sits between the register/control logic and any consumer of a stepped-frequency clock enable, such as chirp generation or frequency-response scans.

## Interface
Parameters:
- `W`, 32, width of the division ratios and of `cnt`.
- `DW`, 16, width of the dwell count.

Ports:
- `clk`  in  1  system clock, single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  sampled only in IDLE; begins a sweep.
- `abort`  in  1  stops the sweep in any state.
- `div_start`  in  W  first ratio; must be ≥2.
- `div_stop`  in  W  final ratio; must be ≥2; may be below `div_start` (down-sweep).
- `div_step`  in  W  ratio increment; must be ≥1.
- `dwell`  in  DW  number of output periods per ratio; must be ≥1.
- `clk_div`  out  1  divided output.
- `cnt`  out  W  position within the current period, 0..cur_div-1.
- `cur_div`  out  W  active ratio.
- `step_tick`  out  1  one-cycle pulse at the end of each ratio's dwell.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse at sweep completion.
- `err`  out  1  one-cycle pulse when `start` is rejected.

## Operation
- Reset values: `clk_div`=1, `cnt`=0, `cur_div`=0, `busy`=0, `done`=0, `err`=0, `step_tick`=0. State is IDLE.
- States are IDLE, RUN and DONE.
- **IDLE, start=1:**
  - If the config is invalid (either ratio <2, step=0 or dwell=0), pulse `err` and stay in IDLE.
  - Otherwise latch all inputs, set `cur_div`=`div_start`, `cnt`=0, `dwell_cnt`=0, `dir`=(`div_stop`≥`div_start`), and go to RUN.
- **RUN, every cycle:**
  - `cnt` advances to `cnt`+1, or to 0 when `cnt`=`cur_div`-1. The latter is a period end.
  - `clk_div`=(next `cnt` < hi), with hi=(`cur_div`+1)>>1. Odd ratios are high for one more cycle than they are low.
- **RUN, period end with `dwell_cnt`≠dwell-1:** increment `dwell_cnt`.
- **RUN, period end with `dwell_cnt`=dwell-1:** pulse `step_tick` and clear `dwell_cnt`. Then:
  - If `cur_div`=`div_stop`, go to DONE.
  - Otherwise compute rem=|`div_stop`-`cur_div`|. If rem≤step, set `cur_div`=`div_stop`; else set `cur_div`=`cur_div`±step.
  - The last ratio is always exactly `div_stop`, and there is never overshoot or wrap.
- **DONE:** `done`=1 for exactly one cycle, `busy`=0, `clk_div`=1, `cnt`=0. Next state is IDLE.
- **abort:** in any state, go to IDLE at the next edge with all outputs at reset values and no `done`. When `abort` and `start` arrive in the same IDLE cycle, `abort` wins and `err` is not evaluated.
- `start` is ignored in RUN and DONE. Inputs are not re-sampled during a sweep.
- `rst` mid-sweep has the same effect as `abort`.

## Timing
- Edge k samples `start`=1 with a valid config. From k+1: `busy`=1, `cnt`=0, `clk_div`=1, `cur_div`=`div_start`.
- A ratio change takes effect on the same edge that returns `cnt` to 0. `step_tick` is high during the cycle after that edge.
- Sweep length: RUN lasts Σ(dwell·d) cycles over the ratio sequence d. `done` is high in the first cycle after RUN.
- `err` is high during cycle k+1, and the block remains in IDLE.
- Arithmetic: compute rem and `cur_div`±step in W+1 bits, then truncate, so a ratio near 2^W-1 cannot wrap. Compare hi against W bits.

## Structure
- Shared package `div_pkg`:
  - state enum {IDLE, RUN, DONE};
  - constant MIN_DIV=2;
  - a function computing the clamped next ratio.
- Sub-module `prog_clk_div`:
  - inputs `clk`, `rst`, `en`, `div` (W bits), `load`;
  - outputs `clk_div`, `cnt`, `period_end`;
  - takes a new `div` only on a period end or on `load`.
- The controller FSM, dwell counter and step logic live in the top level.

## Test plan
- Up-sweep with start=4, stop=10, step=3, dwell=2.
  - Required: ratios 4,7,10; `step_tick` three times; RUN lasts 42 cycles; `done` is a single pulse in cycle 43 after `start`.
- Down-sweep with clamp: start=10, stop=4, step=4, dwell=1.
  - Required: ratios 10,6,4; RUN lasts 20 cycles.
- Duty check with start=stop=7, dwell=3.
  - Required: each period is 4 cycles high and 3 low; one `step_tick`; RUN lasts 21 cycles.
- Invalid config: start=1, or step=0, or dwell=0.
  - Required: one-cycle `err` pulse; `busy` stays 0; no `done`.
- Abort at cycle 9 of the first scenario.
  - Required: next cycle shows `busy`=0, `clk_div`=1, `cnt`=0, `cur_div`=0, and no `done`. A later `start` runs the full 42-cycle sweep.
- Near-max ratios with W=8: start=250, stop=255, step=10, dwell=1.
  - Required: ratios 250,255 with no wrap; `start` pulsed during RUN is ignored.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the divider sweep sequencer.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int MIN_DIV = 2;

    // Widest ratio the helper below supports; W of any instance must not exceed it.
    localparam int MAX_W = 64;

    // Next ratio of the sweep, clamped so it lands exactly on stop and never passes it.
    // Arithmetic is one bit wider than the ratio so values near the top of the range
    // cannot wrap; a carry/borrow out can only mean we went past stop, so clamp there too.
    function automatic logic [MAX_W-1:0] next_ratio(
        input logic [MAX_W-1:0] cur,
        input logic [MAX_W-1:0] stop,
        input logic [MAX_W-1:0] step,
        input logic             up
    );
        logic [MAX_W:0] rem;
        logic [MAX_W:0] nxt;
        if (up) begin
            rem = {1'b0, stop} - {1'b0, cur};
            nxt = {1'b0, cur} + {1'b0, step};
        end else begin
            rem = {1'b0, cur} - {1'b0, stop};
            nxt = {1'b0, cur} - {1'b0, step};
        end
        if (rem <= {1'b0, step} || nxt[MAX_W]) begin
            return stop;
        end
        return nxt[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/prog_clk_div.sv
// Programmable clock divider: counts 0..div-1 and produces a near-50% output.
// A new ratio is accepted only at a period end or on load, so the output never glitches.
module prog_clk_div #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] div,
    input  logic         load,
    output logic         clk_div,
    output logic [W-1:0] cnt,
    output logic         period_end
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] div_q, div_d;
    logic         clk_div_q, clk_div_d;
    logic [W-1:0] hi;

    // Next count, ratio and output level; output is high for the first ceil(div/2) counts.
    always_comb begin
        cnt_d      = cnt_q;
        div_d      = div_q;
        period_end = en && (cnt_q == div_q - W'(1));
        if (load) begin
            cnt_d = '0;
            div_d = div;
        end else if (en) begin
            if (period_end) begin
                cnt_d = '0;
                div_d = div;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end else begin
            cnt_d = '0;
        end
        hi        = W'(({1'b0, div_d} + (W+1)'(1)) >> 1);
        clk_div_d = (load || en) ? (cnt_d < hi) : 1'b1;
    end

    // Divider state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            div_q     <= '0;
            clk_div_q <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            clk_div_q <= clk_div_d;
        end
    end

    assign clk_div = clk_div_q;
    assign cnt     = cnt_q;

endmodule

// File: rtl/div_sweep_ctrl.sv
// Sweep sequencer: steps the divider ratio from div_start to div_stop, holding each
// ratio for dwell output periods.
//
// state | meaning
// IDLE  | waiting for start; config checked when start arrives
// RUN   | divider running, dwell counter and ratio stepping active
// DONE  | one-cycle completion pulse, then back to IDLE
module div_sweep_ctrl
    import div_pkg::*;
#(
    parameter int W  = 32,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [W-1:0]  div_start,
    input  logic [W-1:0]  div_stop,
    input  logic [W-1:0]  div_step,
    input  logic [DW-1:0] dwell,
    output logic          clk_div,
    output logic [W-1:0]  cnt,
    output logic [W-1:0]  cur_div,
    output logic          step_tick,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_e        state_q, state_d;
    logic [W-1:0]  stop_q, stop_d;
    logic [W-1:0]  step_q, step_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          dir_q, dir_d;
    logic [DW-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [W-1:0]  cur_div_q, cur_div_d;
    logic          step_tick_q, step_tick_d;
    logic          err_q, err_d;

    logic          cfg_ok;
    logic          load;
    logic          en;
    logic          period_end;

    assign cfg_ok = (div_start >= W'(MIN_DIV)) && (div_stop >= W'(MIN_DIV)) &&
                    (div_step != '0) && (dwell != '0);

    // Next-state, dwell counting and ratio stepping.
    always_comb begin
        state_d     = state_q;
        stop_d      = stop_q;
        step_d      = step_q;
        dwell_d     = dwell_q;
        dir_d       = dir_q;
        dwell_cnt_d = dwell_cnt_q;
        cur_div_d   = cur_div_q;
        step_tick_d = 1'b0;
        err_d       = 1'b0;
        load        = 1'b0;
        en          = 1'b0;
        case (state_q)
            IDLE: begin
                if (abort) begin
                    cur_div_d = '0;
                end else if (start) begin
                    if (cfg_ok) begin
                        load        = 1'b1;
                        stop_d      = div_stop;
                        step_d      = div_step;
                        dwell_d     = dwell;
                        dir_d       = (div_stop >= div_start);
                        dwell_cnt_d = '0;
                        cur_div_d   = div_start;
                        state_d     = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    cur_div_d   = '0;
                    dwell_cnt_d = '0;
                    state_d     = IDLE;
                end else begin
                    en = 1'b1;
                    if (period_end) begin
                        if (dwell_cnt_q == dwell_q - DW'(1)) begin
                            step_tick_d = 1'b1;
                            dwell_cnt_d = '0;
                            if (cur_div_q == stop_q) begin
                                state_d = DONE;
                            end else begin
                                cur_div_d = W'(next_ratio(MAX_W'(cur_div_q), MAX_W'(stop_q),
                                                          MAX_W'(step_q), dir_q));
                            end
                        end else begin
                            dwell_cnt_d = dwell_cnt_q + DW'(1);
                        end
                    end
                end
            end
            DONE: begin
                if (abort) begin
                    cur_div_d = '0;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            stop_q      <= '0;
            step_q      <= '0;
            dwell_q     <= '0;
            dir_q       <= 1'b0;
            dwell_cnt_q <= '0;
            cur_div_q   <= '0;
            step_tick_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            stop_q      <= stop_d;
            step_q      <= step_d;
            dwell_q     <= dwell_d;
            dir_q       <= dir_d;
            dwell_cnt_q <= dwell_cnt_d;
            cur_div_q   <= cur_div_d;
            step_tick_q <= step_tick_d;
            err_q       <= err_d;
        end
    end

    prog_clk_div #(.W(W)) u_div (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .div        (cur_div_d),
        .load       (load),
        .clk_div    (clk_div),
        .cnt        (cnt),
        .period_end (period_end)
    );

    assign cur_div   = cur_div_q;
    assign step_tick = step_tick_q;
    assign err       = err_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_div_sweep_ctrl.sv
// Bench for div_sweep_ctrl: a 32-bit and an 8-bit instance share stimulus and are both
// compared every cycle against a cycle-trace model built from the sweep rules.
module tb_div_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [31:0] div_start, div_stop, div_step;
    logic [15:0] dwell;

    logic        a_clk, a_tick, a_busy, a_done, a_err;
    logic [31:0] a_cnt, a_cur;
    logic        b_clk, b_tick, b_busy, b_done, b_err;
    logic [7:0]  b_cnt, b_cur;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_sweep_ctrl #(.W(32), .DW(16)) dut32 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .div_start(div_start), .div_stop(div_stop), .div_step(div_step), .dwell(dwell),
        .clk_div(a_clk), .cnt(a_cnt), .cur_div(a_cur), .step_tick(a_tick),
        .busy(a_busy), .done(a_done), .err(a_err)
    );

    div_sweep_ctrl #(.W(8), .DW(16)) dut8 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .div_start(div_start[7:0]), .div_stop(div_stop[7:0]), .div_step(div_step[7:0]),
        .dwell(dwell),
        .clk_div(b_clk), .cnt(b_cnt), .cur_div(b_cur), .step_tick(b_tick),
        .busy(b_busy), .done(b_done), .err(b_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- model: expected per-cycle trace ----------------
    typedef struct {
        bit     clk_div;
        longint cnt;
        longint cur_div;
        bit     chk_div;
        bit     step_tick;
        bit     busy;
        bit     done;
        bit     err;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   cur_e;
    bit     idle_known = 1;
    longint idle_val   = 0;

    function automatic exp_t idle_exp(bit e, bit known, longint v);
        exp_t x;
        x.clk_div = 1; x.cnt = 0; x.cur_div = v; x.chk_div = known;
        x.step_tick = 0; x.busy = 0; x.done = 0; x.err = e;
        return x;
    endfunction

    task automatic build_trace(input longint s, input longint e, input longint st, input longint dw);
        longint d;
        longint rem;
        exp_t   x;
        int     i;
        d = s;
        i = 0;
        while (i < 1000) begin
            for (longint rep = 0; rep < dw; rep++) begin
                for (longint c = 0; c < d; c++) begin
                    x.clk_div   = (c < (d + 1) / 2);
                    x.cnt       = c;
                    x.cur_div   = d;
                    x.chk_div   = 1;
                    x.step_tick = (i > 0 && rep == 0 && c == 0);
                    x.busy      = 1;
                    x.done      = 0;
                    x.err       = 0;
                    exp_q.push_back(x);
                end
            end
            if (d == e) break;
            rem = (e > d) ? e - d : d - e;
            if (rem <= st) d = e;
            else d = (e > d) ? d + st : d - st;
            i++;
        end
        x = idle_exp(0, 0, 0);
        x.step_tick = 1;
        x.done      = 1;
        exp_q.push_back(x);
    endtask

    always @(posedge clk) begin
        bit e;
        e = 0;
        if (rst || abort) begin
            exp_q.delete();
            idle_known = 1;
            idle_val   = 0;
            cur_e      = idle_exp(0, 1, 0);
        end else begin
            if (!cur_e.busy && !cur_e.done && start) begin
                if (div_start < 2 || div_stop < 2 || div_step == 0 || dwell == 0) e = 1;
                else build_trace(div_start, div_stop, div_step, dwell);
            end
            if (exp_q.size() > 0) begin
                cur_e = exp_q.pop_front();
                if (cur_e.done) idle_known = 0;
            end else begin
                cur_e = idle_exp(e, idle_known, idle_val);
            end
        end
    end

    task automatic cmp(input string tag, input logic ck, input logic [63:0] cn,
                       input logic [63:0] cd, input logic tk, input logic bs,
                       input logic dn, input logic er);
        chk({tag, " clk_div"}, ck, cur_e.clk_div);
        chk({tag, " cnt"}, cn, cur_e.cnt);
        if (cur_e.chk_div) chk({tag, " cur_div"}, cd, cur_e.cur_div);
        chk({tag, " step_tick"}, tk, cur_e.step_tick);
        chk({tag, " busy"}, bs, cur_e.busy);
        chk({tag, " done"}, dn, cur_e.done);
        chk({tag, " err"}, er, cur_e.err);
    endtask

    always @(negedge clk) begin
        cmp("w32", a_clk, a_cnt, a_cur, a_tick, a_busy, a_done, a_err);
        cmp("w8", b_clk, b_cnt, b_cur, b_tick, b_busy, b_done, b_err);
    end

    // ---------------- directed scenarios with literal expectations ----------------
    task automatic sweep(input int s, input int e, input int st, input int dw,
                         input int exp_len, input int exp_ticks, input int exp_high,
                         input int n_r, input int r0, input int r1, input int r2,
                         input bit mid_start, input string nm);
        int busy_n, ticks, high_n, cyc, done_cyc, nr;
        bit got_done;
        int rec[8];
        int req[3];
        req[0] = r0; req[1] = r1; req[2] = r2;
        @(negedge clk);
        div_start = s; div_stop = e; div_step = st; dwell = 16'(dw);
        start = 1;
        @(negedge clk);
        start = 0;
        busy_n = 0; ticks = 0; high_n = 0; cyc = 1; done_cyc = 0; nr = 0; got_done = 0;
        while (cyc < 2000 && !got_done) begin
            if (a_busy) begin
                busy_n++;
                if (a_clk) high_n++;
                if (nr == 0 || a_cur != rec[(nr - 1) % 8]) begin
                    rec[nr % 8] = a_cur;
                    nr++;
                end
            end
            if (a_tick) ticks++;
            if (a_done) begin
                got_done = 1;
                done_cyc = cyc;
            end else begin
                start = (mid_start && cyc == 20);
                @(negedge clk);
                cyc++;
            end
        end
        start = 0;
        chk({nm, " done seen"}, got_done, 1);
        chk({nm, " run length"}, busy_n, exp_len);
        chk({nm, " done cycle"}, done_cyc, exp_len + 1);
        chk({nm, " step_ticks"}, ticks, exp_ticks);
        chk({nm, " high cycles"}, high_n, exp_high);
        chk({nm, " ratio count"}, nr, n_r);
        for (int i = 0; i < n_r && i < 3; i++) chk({nm, " ratio"}, rec[i], req[i]);
        @(negedge clk);
        chk({nm, " done width"}, a_done, 0);
    endtask

    task automatic bad(input int s, input int e, input int st, input int dw,
                       input bit with_abort, input string nm);
        bit seen;
        @(negedge clk);
        div_start = s; div_stop = e; div_step = st; dwell = 16'(dw);
        start = 1; abort = with_abort;
        @(negedge clk);
        start = 0; abort = 0;
        chk({nm, " err"}, a_err, with_abort ? 0 : 1);
        chk({nm, " busy"}, a_busy, 0);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (a_done || a_busy || a_err) seen = 1;
        end
        chk({nm, " quiet after"}, seen, 0);
    endtask

    initial begin
        bit seen;
        rst = 1; start = 0; abort = 0;
        div_start = 0; div_stop = 0; div_step = 0; dwell = 0;
        repeat (3) @(negedge clk);
        chk("reset clk_div", a_clk, 1);
        chk("reset cnt", a_cnt, 0);
        chk("reset cur_div", a_cur, 0);
        chk("reset busy", a_busy, 0);
        rst = 0;
        repeat (2) @(negedge clk);

        sweep(4, 10, 3, 2, 42, 3, 22, 3, 4, 7, 10, 0, "up");
        sweep(10, 4, 4, 1, 20, 3, 10, 3, 10, 6, 4, 0, "down");
        sweep(7, 7, 1, 3, 21, 1, 12, 1, 7, 0, 0, 0, "duty");
        sweep(250, 255, 10, 1, 505, 2, 253, 2, 250, 255, 0, 1, "nearmax");

        bad(1, 10, 3, 2, 0, "bad start");
        bad(4, 1, 3, 2, 0, "bad stop");
        bad(4, 10, 0, 2, 0, "bad step");
        bad(4, 10, 3, 0, 0, "bad dwell");
        bad(4, 10, 0, 2, 1, "abort beats start");

        // abort during cycle 9 of the up-sweep
        @(negedge clk);
        div_start = 4; div_stop = 10; div_step = 3; dwell = 2;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (8) @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("abort busy", a_busy, 0);
        chk("abort clk_div", a_clk, 1);
        chk("abort cnt", a_cnt, 0);
        chk("abort cur_div", a_cur, 0);
        chk("abort done", a_done, 0);
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (a_done || b_done) seen = 1;
        end
        chk("abort no done", seen, 0);
        sweep(4, 10, 3, 2, 42, 3, 22, 3, 4, 7, 10, 0, "after abort");

        // reset in the middle of a sweep
        @(negedge clk);
        div_start = 10; div_stop = 4; div_step = 4; dwell = 1;
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (5) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("midrst busy", a_busy, 0);
        chk("midrst cur_div", a_cur, 0);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
